contador_parametrizado: RTL
===========================

# contador_parametrizado

Parametrised up/down counter, WIDTH bits wide, with runtime-programmable bounds, step size, synchronous load and three counting modes: up-wrap, down-wrap and bounce (ping-pong). It extends the team's 4-bit bounce counter with enable, load, programmable limits and a terminal-count pulse. It is intended as a reusable sequencer/address generator in the exercise designs, driven from the single system clock.

## Interface
- WIDTH, 4, counter width in bits (≥2).
- CLK  in  1  system clock; all state changes on rising edge.
- R  in  1  reset, synchronous and active-high.
- EN  in  1  count enable; one step per cycle while high.
- MODE  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- LD  in  1  synchronous load strobe.
- LD_VAL  in  WIDTH  value loaded into O when LD=1.
- LO  in  WIDTH  lower bound (inclusive).
- HI  in  WIDTH  upper bound (inclusive).
- STEP  in  WIDTH  increment/decrement magnitude; 0 is treated as 1.
- O  out  WIDTH  counter value (registered).
- DIR  out  1  current direction, 0 = up, 1 = down (registered).
- TC  out  1  terminal-count pulse (registered, one cycle per wrap/turn).

## Operation
- Priority per edge: R > LD > (EN and MODE≠11) > hold.
- R=1: O←0, DIR←0, TC←0.
- LD=1: O←LD_VAL, DIR unchanged, TC←0; EN ignored that cycle.
- EN=0 or MODE=11: O, DIR unchanged; TC←0.
- Let S = (STEP==0) ? 1 : STEP. All sums/differences evaluated in WIDTH+1 bits; no modular wrap of the arithmetic itself.
- Degenerate bounds (LO ≥ HI) during a counting step: O←LO, DIR unchanged, TC←0.
- Up-wrap (00), DIR←0: if O ≥ HI or O+S > HI: O←LO, TC←1; else O←O+S, TC←0.
- Down-wrap (01), DIR←1: if O ≤ LO or O−S < LO (signed compare): O←HI, TC←1; else O←O−S, TC←0.
- Bounce (10):
  - DIR=0: if O ≥ HI: O←max(O−S, LO), DIR←1, TC←1; else O←min(O+S, HI), TC←0.
  - DIR=1: if O ≤ LO: O←min(O+S, HI), DIR←0, TC←1; else O←max(O−S, LO), TC←0.
  - With S=1, LO=0, HI=2^WIDTH−1 the sequence matches the legacy counter: 0,1,…,max,max−1,…,0,1,…
- O outside [LO,HI] (bounds changed at runtime): rules above apply unchanged; up from below LO climbs by S clamped/wrapped at HI; down from above HI descends by S clamped/wrapped at LO.
- MODE may change any cycle; the new mode takes effect on the next edge using the current O and DIR.

## Timing
- All outputs registered; O, DIR, TC update on the same rising edge, no combinational input→output paths.
- Latency: inputs sampled at edge k appear on outputs after edge k.
- TC high for exactly the cycle following a wrap or turn; with HI−LO ≥ 1 and S=1 TC never stays high on consecutive cycles except at LO=HI−1 in bounce (turns every cycle, TC stays high).
- Reset mid-count: next edge forces O=0, DIR=0, TC=0 regardless of EN/LD.
- LD and EN both high: load wins, no step that cycle.

## Test plan
- WIDTH=4, R pulse, MODE=10, EN=1, LO=0, HI=15, STEP=1 -> O: 0,1,…,15,14,…,0,1; DIR rises after O=15 edge, falls after O=0 edge; TC high on the cycles showing 14 and 1 after turns.
- MODE=00, LO=3, HI=9, STEP=4, LD with LD_VAL=3 -> O: 3,7,3,7 (7+4>9 wraps to LO); TC=1 on each 3 after 7.
- MODE=01, LO=2, HI=12, STEP=5, load 12 -> O: 12,7,2,12,7; TC=1 when O returns to 12; DIR=1 throughout.
- MODE=10, LO=4, HI=10, STEP=4, load 4, DIR=0 -> O: 4,8,10,6,4,8; DIR flips after 10 and after 4; check clamping to HI/LO.
- Priority: EN=1, LD=1 LD_VAL=5 with R=1 -> O=0; next cycle R=0, LD=1 -> O=5, TC=0; MODE=11 for 3 cycles -> O stays 5.
- Degenerate/edge: LO=HI=6 with EN=1 -> O=6, TC=0 every cycle; STEP=0 in MODE=00 from 0, HI=15 -> counts by 1.

Source files
------------

// File: rtl/contador_parametrizado.sv
// Parametrised up/down/bounce counter with programmable bounds, step, load and
// a registered terminal-count pulse.
module contador_parametrizado #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic [WIDTH-1:0] LO,
    input  logic [WIDTH-1:0] HI,
    input  logic [WIDTH-1:0] STEP,
    output logic [WIDTH-1:0] O,
    output logic             DIR,
    output logic             TC
);

    // Two guard bits: one for the carry of O+S, one for the sign of O-S.
    localparam int XW = WIDTH + 2;

    typedef logic signed [XW-1:0] ext_t;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    function automatic ext_t widen(input logic [WIDTH-1:0] v);
        return ext_t'({2'b00, v});
    endfunction

    function automatic logic [WIDTH-1:0] sat_hi(input ext_t v, input logic [WIDTH-1:0] hi);
        return (v > widen(hi)) ? hi : v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_lo(input ext_t v, input logic [WIDTH-1:0] lo);
        return (v < widen(lo)) ? lo : v[WIDTH-1:0];
    endfunction

    mode_t mode;
    ext_t  o_x, lo_x, hi_x, s_x, up_x, dn_x;

    assign mode = mode_t'(MODE);
    assign o_x  = widen(O);
    assign lo_x = widen(LO);
    assign hi_x = widen(HI);
    assign s_x  = (STEP == '0) ? ext_t'(1) : widen(STEP);
    assign up_x = o_x + s_x;
    assign dn_x = o_x - s_x;

    always_ff @(posedge CLK) begin
        if (R) begin
            O   <= '0;
            DIR <= 1'b0;
            TC  <= 1'b0;
        end else if (LD) begin
            O  <= LD_VAL;
            TC <= 1'b0;
        end else if (!EN || mode == MODE_HOLD) begin
            TC <= 1'b0;
        end else if (lo_x >= hi_x) begin
            O  <= LO;
            TC <= 1'b0;
        end else begin
            case (mode)
                MODE_UP: begin
                    DIR <= 1'b0;
                    if (o_x >= hi_x || up_x > hi_x) begin
                        O  <= LO;
                        TC <= 1'b1;
                    end else begin
                        O  <= up_x[WIDTH-1:0];
                        TC <= 1'b0;
                    end
                end
                MODE_DOWN: begin
                    DIR <= 1'b1;
                    if (o_x <= lo_x || dn_x < lo_x) begin
                        O  <= HI;
                        TC <= 1'b1;
                    end else begin
                        O  <= dn_x[WIDTH-1:0];
                        TC <= 1'b0;
                    end
                end
                MODE_BOUNCE: begin
                    // Turning edges move immediately in the new direction.
                    if (!DIR) begin
                        if (o_x >= hi_x) begin
                            O   <= sat_lo(dn_x, LO);
                            DIR <= 1'b1;
                            TC  <= 1'b1;
                        end else begin
                            O  <= sat_hi(up_x, HI);
                            TC <= 1'b0;
                        end
                    end else begin
                        if (o_x <= lo_x) begin
                            O   <= sat_hi(up_x, HI);
                            DIR <= 1'b0;
                            TC  <= 1'b1;
                        end else begin
                            O  <= sat_lo(dn_x, LO);
                            TC <= 1'b0;
                        end
                    end
                end
                default: TC <= 1'b0;
            endcase
        end
    end

endmodule
